// File: rtl/axi_lite_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_mem_ctrl
// Description : AXI4-Lite slave that drives the write/read ports of a
//               synchronous memory with a one-cycle registered read.
// Revision    : 1.0 - initial release
// ============================================================================

module axi_lite_mem_ctrl #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 4,
    parameter int ADDR_LSB = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    // write address / data / response
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [DEPTH+ADDR_LSB-1:0] AWADDR,
    input  logic                      WVALID,
    output logic                      WREADY,
    input  logic [WIDTH-1:0]          WDATA,
    output logic                      BVALID,
    input  logic                      BREADY,
    output logic [1:0]                BRESP,
    // read address / data
    input  logic                      ARVALID,
    output logic                      ARREADY,
    input  logic [DEPTH+ADDR_LSB-1:0] ARADDR,
    output logic                      RVALID,
    input  logic                      RREADY,
    output logic [WIDTH-1:0]          RDATA,
    output logic [1:0]                RRESP,
    // memory ports
    output logic                      MEM_WEN,
    output logic                      MEM_REN,
    output logic [DEPTH-1:0]          MEM_WADDR,
    output logic [DEPTH-1:0]          MEM_RADDR,
    output logic [WIDTH-1:0]          MEM_DIN,
    input  logic [WIDTH-1:0]          MEM_DOUT
);

    localparam logic [1:0] c_W_IDLE  = 2'd0;
    localparam logic [1:0] c_W_ISSUE = 2'd1;
    localparam logic [1:0] c_W_RESP  = 2'd2;

    localparam logic [1:0] c_R_IDLE  = 2'd0;
    localparam logic [1:0] c_R_ISSUE = 2'd1;
    localparam logic [1:0] c_R_WAIT  = 2'd2;
    localparam logic [1:0] c_R_RESP  = 2'd3;

    logic [1:0]       r_wstate;
    logic [1:0]       r_rstate;
    logic             r_awready;
    logic             r_wready;
    logic             r_arready;
    logic             r_bvalid;
    logic             r_rvalid;
    logic             r_aw_held;
    logic             r_w_held;
    logic [DEPTH-1:0] r_aw_addr;
    logic [WIDTH-1:0] r_w_data;
    logic             r_mem_wen;
    logic             r_mem_ren;
    logic [DEPTH-1:0] r_mem_waddr;
    logic [DEPTH-1:0] r_mem_raddr;
    logic [WIDTH-1:0] r_mem_din;
    logic [WIDTH-1:0] r_rdata;

    logic             w_aw_hs;
    logic             w_w_hs;
    logic             w_ar_hs;
    logic             w_aw_next;
    logic             w_w_next;
    logic [DEPTH-1:0] w_aw_word;
    logic [DEPTH-1:0] w_ar_word;
    logic             w_unused_addr_lsb;

    // Readies are registered, so they are only ever high in the idle states.
    assign w_aw_hs   = AWVALID && r_awready;
    assign w_w_hs    = WVALID  && r_wready;
    assign w_ar_hs   = ARVALID && r_arready;
    assign w_aw_next = r_aw_held || w_aw_hs;
    assign w_w_next  = r_w_held  || w_w_hs;
    assign w_aw_word = AWADDR[ADDR_LSB+DEPTH-1:ADDR_LSB];
    assign w_ar_word = ARADDR[ADDR_LSB+DEPTH-1:ADDR_LSB];

    // Byte-offset bits carry no meaning for whole-word accesses.
    assign w_unused_addr_lsb = ^{AWADDR[ADDR_LSB-1:0], ARADDR[ADDR_LSB-1:0]};

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wstate    <= c_W_IDLE;
            r_awready   <= 1'b0;
            r_wready    <= 1'b0;
            r_bvalid    <= 1'b0;
            r_aw_held   <= 1'b0;
            r_w_held    <= 1'b0;
            r_aw_addr   <= '0;
            r_w_data    <= '0;
            r_mem_wen   <= 1'b0;
            r_mem_waddr <= '0;
            r_mem_din   <= '0;
        end else begin
            case (r_wstate)
                c_W_IDLE: begin
                    if (w_aw_hs) r_aw_addr <= w_aw_word;
                    if (w_w_hs)  r_w_data  <= WDATA;
                    r_aw_held <= w_aw_next;
                    r_w_held  <= w_w_next;
                    if (w_aw_next && w_w_next) begin
                        // Forward a same-cycle handshake straight to the memory port.
                        r_wstate    <= c_W_ISSUE;
                        r_mem_wen   <= 1'b1;
                        r_mem_waddr <= w_aw_hs ? w_aw_word : r_aw_addr;
                        r_mem_din   <= w_w_hs  ? WDATA     : r_w_data;
                        r_awready   <= 1'b0;
                        r_wready    <= 1'b0;
                    end else begin
                        r_awready   <= !w_aw_next;
                        r_wready    <= !w_w_next;
                    end
                end
                c_W_ISSUE: begin
                    r_mem_wen <= 1'b0;
                    r_aw_held <= 1'b0;
                    r_w_held  <= 1'b0;
                    r_bvalid  <= 1'b1;
                    r_wstate  <= c_W_RESP;
                end
                c_W_RESP: begin
                    if (BREADY) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= c_W_IDLE;
                    end
                end
                default: begin
                    r_mem_wen <= 1'b0;
                    r_bvalid  <= 1'b0;
                    r_wstate  <= c_W_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rstate    <= c_R_IDLE;
            r_arready   <= 1'b0;
            r_rvalid    <= 1'b0;
            r_mem_ren   <= 1'b0;
            r_mem_raddr <= '0;
            r_rdata     <= '0;
        end else begin
            case (r_rstate)
                c_R_IDLE: begin
                    if (w_ar_hs) begin
                        r_mem_raddr <= w_ar_word;
                        r_mem_ren   <= 1'b1;
                        r_arready   <= 1'b0;
                        r_rstate    <= c_R_ISSUE;
                    end else begin
                        r_arready   <= 1'b1;
                    end
                end
                c_R_ISSUE: begin
                    r_mem_ren <= 1'b0;
                    r_rstate  <= c_R_WAIT;
                end
                c_R_WAIT: begin
                    // Memory output is valid one cycle after the read strobe.
                    r_rdata  <= MEM_DOUT;
                    r_rvalid <= 1'b1;
                    r_rstate <= c_R_RESP;
                end
                c_R_RESP: begin
                    if (RREADY) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= c_R_IDLE;
                    end
                end
                default: begin
                    r_mem_ren <= 1'b0;
                    r_rvalid  <= 1'b0;
                    r_rstate  <= c_R_IDLE;
                end
            endcase
        end
    end

    assign AWREADY   = r_awready;
    assign WREADY    = r_wready;
    assign BVALID    = r_bvalid;
    assign BRESP     = 2'b00;
    assign ARREADY   = r_arready;
    assign RVALID    = r_rvalid;
    assign RDATA     = r_rdata;
    assign RRESP     = 2'b00;
    assign MEM_WEN   = r_mem_wen;
    assign MEM_REN   = r_mem_ren;
    assign MEM_WADDR = r_mem_waddr;
    assign MEM_RADDR = r_mem_raddr;
    assign MEM_DIN   = r_mem_din;

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_mem_ctrl
// Description : Directed and randomized bench for axi_lite_mem_ctrl with a
//               behavioural memory and a word-level reference of its contents.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_axi_lite_mem_ctrl;

    localparam int WIDTH    = 32;
    localparam int DEPTH    = 4;
    localparam int ADDR_LSB = 2;
    localparam int AW       = DEPTH + ADDR_LSB;
    localparam int LIM      = 20;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0;
    logic             ARVALID = 1'b0, RREADY = 1'b0;
    logic [AW-1:0]    AWADDR = '0, ARADDR = '0;
    logic [WIDTH-1:0] WDATA = '0;
    logic             AWREADY, WREADY, BVALID, ARREADY, RVALID;
    logic [1:0]       BRESP, RRESP;
    logic [WIDTH-1:0] RDATA, MEM_DIN;
    logic             MEM_WEN, MEM_REN;
    logic [DEPTH-1:0] MEM_WADDR, MEM_RADDR;
    logic [WIDTH-1:0] MEM_DOUT = '0;

    logic [WIDTH-1:0] mem_arr [2**DEPTH] = '{default: '0};
    logic [WIDTH-1:0] ref_mem [2**DEPTH] = '{default: '0};

    int tests = 0;
    int fails = 0;

    axi_lite_mem_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_LSB(ADDR_LSB)) dut (
        .CLK(CLK), .RST(RST),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .MEM_WEN(MEM_WEN), .MEM_REN(MEM_REN),
        .MEM_WADDR(MEM_WADDR), .MEM_RADDR(MEM_RADDR),
        .MEM_DIN(MEM_DIN), .MEM_DOUT(MEM_DOUT)
    );

    always #5 CLK = ~CLK;

    // Synchronous memory: registered read that holds when not enabled, read-before-write.
    always @(posedge CLK) begin
        if (MEM_REN) MEM_DOUT <= mem_arr[MEM_RADDR];
        if (MEM_WEN) mem_arr[MEM_WADDR] <= MEM_DIN;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, {AWREADY, WREADY, ARREADY, BVALID, RVALID, MEM_WEN, MEM_REN}, 0);
        chk({tag, "_resp"}, {BRESP, RRESP}, 0);
        chk({tag, "_rdata"}, RDATA, 0);
        chk({tag, "_din"}, MEM_DIN, 0);
        chk({tag, "_addrs"}, {MEM_WADDR, MEM_RADDR}, 0);
    endtask

    // gap < 0: AW and W together; gap >= 1: W first, AW presented gap cycles later.
    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                             input int gap, input int bdelay);
        int n;
        logic [DEPTH-1:0] word;
        word = addr[AW-1:ADDR_LSB];
        if (gap < 0) begin
            AWADDR = addr; WDATA = data; AWVALID = 1'b1; WVALID = 1'b1;
            n = 0;
            while (!(AWREADY && WREADY) && n < LIM) begin @(negedge CLK); n++; end
            chk("aw_w_ready_timeout", n < LIM, 1);
            @(negedge CLK);
            AWVALID = 1'b0; WVALID = 1'b0;
        end else begin
            WDATA = data; WVALID = 1'b1;
            n = 0;
            while (!WREADY && n < LIM) begin @(negedge CLK); n++; end
            chk("w_ready_timeout", n < LIM, 1);
            @(negedge CLK);
            WVALID = 1'b0;
            chk("wready_drop", WREADY, 0);
            repeat (gap - 1) @(negedge CLK);
            chk("wready_stays_low", WREADY, 0);
            chk("awready_waiting", AWREADY, 1);
            chk("no_early_wen", MEM_WEN, 0);
            AWADDR = addr; AWVALID = 1'b1;
            n = 0;
            while (!AWREADY && n < LIM) begin @(negedge CLK); n++; end
            chk("aw_ready_timeout", n < LIM, 1);
            @(negedge CLK);
            AWVALID = 1'b0;
        end
        chk("mem_wen", MEM_WEN, 1);
        chk("mem_waddr", MEM_WADDR, word);
        chk("mem_din", MEM_DIN, data);
        ref_mem[word] = data;
        @(negedge CLK);
        chk("wen_one_cycle", MEM_WEN, 0);
        chk("bvalid", BVALID, 1);
        chk("bresp", BRESP, 0);
        chk("aw_w_busy", {AWREADY, WREADY}, 0);
        repeat (bdelay) begin
            @(negedge CLK);
            chk("bvalid_hold", BVALID, 1);
            chk("aw_w_busy_hold", {AWREADY, WREADY}, 0);
        end
        BREADY = 1'b1;
        @(negedge CLK);
        BREADY = 1'b0;
        chk("bvalid_clear", BVALID, 0);
        chk("aw_w_ready_back", {AWREADY, WREADY}, 2'b11);
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input logic [31:0] exp,
                            input int rdelay);
        int n;
        ARADDR = addr; ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < LIM) begin @(negedge CLK); n++; end
        chk("ar_ready_timeout", n < LIM, 1);
        @(negedge CLK);
        ARVALID = 1'b0;
        chk("mem_ren", MEM_REN, 1);
        chk("mem_raddr", MEM_RADDR, addr[AW-1:ADDR_LSB]);
        chk("arready_busy", ARREADY, 0);
        @(negedge CLK);
        chk("ren_one_cycle", MEM_REN, 0);
        chk("rvalid_early", RVALID, 0);
        @(negedge CLK);
        chk("rvalid", RVALID, 1);
        chk("rdata", RDATA, exp);
        chk("rresp", RRESP, 0);
        repeat (rdelay) begin
            @(negedge CLK);
            chk("rvalid_hold", RVALID, 1);
            chk("rdata_hold", RDATA, exp);
            chk("arready_hold", ARREADY, 0);
        end
        RREADY = 1'b1;
        @(negedge CLK);
        RREADY = 1'b0;
        chk("rvalid_clear", RVALID, 0);
        chk("arready_back", ARREADY, 1);
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [31:0]   d;
        int            g;
        int            n;

        // Reset state and ready release
        repeat (3) @(negedge CLK);
        chk_all_zero("reset");
        RST = 1'b0;
        @(negedge CLK);
        chk("ready_after_reset", {AWREADY, WREADY, ARREADY}, 3'b111);

        // Write-then-read
        axi_write(6'h08, 32'hDEADBEEF, -1, 0);
        axi_read(6'h08, 32'hDEADBEEF, 0);

        // Split write, W five cycles ahead of AW
        axi_write(6'h3C, 32'h12345678, 5, 0);
        axi_read(6'h3C, 32'h12345678, 0);

        // Backpressure on both response channels at once
        fork
            axi_write(6'h10, 32'hCAFEF00D, -1, 10);
            axi_read(6'h08, 32'hDEADBEEF, 10);
        join
        axi_read(6'h10, 32'hCAFEF00D, 0);

        // Same-cycle write/read strobes return old data; a later read sees the new
        axi_write(6'h04, 32'h0000000A, -1, 0);
        fork
            axi_write(6'h04, 32'h0000000B, -1, 0);
            axi_read(6'h04, 32'h0000000A, 0);
        join
        axi_read(6'h04, 32'h0000000B, 0);

        // Top word and byte-offset aliasing
        axi_write(6'h3C, 32'h00000055, -1, 0);
        axi_read(6'h3C, 32'h00000055, 0);
        axi_write(6'h3D, 32'h00000066, 2, 0);
        axi_read(6'h3C, 32'h00000066, 0);

        // Reset while the read is waiting on memory data
        ARADDR = 6'h08; ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < LIM) begin @(negedge CLK); n++; end
        chk("rst_ar_timeout", n < LIM, 1);
        @(negedge CLK);
        ARVALID = 1'b0;
        chk("rst_mem_ren", MEM_REN, 1);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk_all_zero("mid_read_reset");
        @(negedge CLK);
        chk("no_rvalid_after_reset", RVALID, 0);
        chk("ready_after_mid_reset", {AWREADY, WREADY, ARREADY}, 3'b111);
        axi_read(6'h08, ref_mem[2], 0);

        // Randomized traffic against the word-level reference
        for (int i = 0; i < 16; i++) begin
            a = AW'($urandom_range(0, 2**AW - 1));
            d = $urandom;
            g = int'($urandom_range(0, 3));
            axi_write(a, d, (g == 0) ? -1 : g, int'($urandom_range(0, 3)));
            a = AW'($urandom_range(0, 2**AW - 1));
            axi_read(a, ref_mem[a[AW-1:ADDR_LSB]], int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axi_lite_mem_ctrl.md
# axi_lite_mem_ctrl

AXI4-Lite slave front-end that owns the write and read ports of a single-clock synchronous memory. The memory has independent write and read ports, a one-cycle registered read, and holds its output when its read enable is low. This block converts AXI4-Lite write (AW/W/B) and read (AR/R) transactions into memory write and read strobes, and sits between the bus interconnect and a memory instance. The write and read channels run independent FSMs, so one write and one read can be in flight at once.

## Interface
- WIDTH, 32: data width of WDATA, RDATA and the memory words
- DEPTH, 4: memory address bits; the memory holds 2^DEPTH words
- ADDR_LSB, 2: byte-offset bits dropped from AXI addresses (log2(WIDTH/8))
- CLK  in  1  clock; everything is sampled on the rising edge
- RST  in  1  synchronous, active-high reset
- AWVALID, AWREADY  in, out  1  write-address handshake
- AWADDR  in  DEPTH+ADDR_LSB  write byte address
- WVALID, WREADY  in, out  1  write-data handshake
- WDATA  in  WIDTH  write data; the whole word is always written
- BVALID, BREADY  out, in  1  write-response handshake
- BRESP  out  2  always 2'b00 (OKAY)
- ARVALID, ARREADY  in, out  1  read-address handshake
- ARADDR  in  DEPTH+ADDR_LSB  read byte address
- RVALID, RREADY  out, in  1  read-data handshake
- RDATA  out  WIDTH  read data, registered
- RRESP  out  2  always 2'b00 (OKAY)
- MEM_WEN, MEM_REN  out  1  memory write and read strobes, one cycle wide
- MEM_WADDR, MEM_RADDR  out  DEPTH  memory word addresses, registered
- MEM_DIN  out  WIDTH  memory write data, registered
- MEM_DOUT  in  WIDTH  memory read data; valid the cycle after MEM_REN

## Operation
- Word address = AxADDR[ADDR_LSB+DEPTH-1:ADDR_LSB]. The byte-offset bits are ignored.
- Write FSM:
  - W_IDLE:
    - AWREADY = !aw_held. WREADY = !w_held.
    - An AW handshake latches the address and sets aw_held. A W handshake latches the data and sets w_held. AW and W may arrive in either order or in the same cycle.
    - When both are held, or complete in the current cycle, the FSM moves to W_ISSUE.
  - W_ISSUE:
    - MEM_WEN=1 for exactly one cycle, with MEM_WADDR and MEM_DIN taken from the latched values.
    - Clears both held flags and moves to W_RESP.
  - W_RESP:
    - BVALID=1 until BREADY is sampled high, then back to W_IDLE.
    - AWREADY and WREADY stay 0 in W_ISSUE and W_RESP.
- Read FSM:
  - R_IDLE: ARREADY=1. An AR handshake latches the address and moves to R_ISSUE.
  - R_ISSUE: MEM_REN=1 for one cycle, MEM_RADDR from the latch. Next state R_WAIT.
  - R_WAIT: RDATA <= MEM_DOUT. Next state R_RESP.
  - R_RESP: RVALID=1 and RDATA is held stable until RREADY is sampled high, then back to R_IDLE.
  - ARREADY=0 outside R_IDLE.
- MEM_WEN and MEM_REN are 0 in every other state.
- The two channels never stall each other.

## Timing
- Reset values:
  - AWREADY, WREADY, ARREADY, BVALID, RVALID, MEM_WEN, MEM_REN all 0.
  - RDATA, MEM_DIN, MEM_WADDR, MEM_RADDR all 0. BRESP, RRESP 0.
  - Both FSMs idle, held flags cleared.
- The ready outputs rise in the first cycle after RST deasserts.
- Write latency, with the last of AW/W accepted in cycle T:
  - MEM_WEN=1 in T+1.
  - BVALID=1 from T+2.
  - With BREADY held high, the next AW/W can be accepted in T+3.
- Read latency, with AR accepted in cycle T:
  - MEM_REN=1 in T+1.
  - MEM_DOUT valid in T+2 and captured at the end of T+2.
  - RVALID=1 from T+3.
  - With RREADY held high, the next AR can be accepted in T+4.
- Backpressure: BVALID and RVALID may wait indefinitely. RDATA does not change while RVALID=1 and RREADY=0.
- Write and read to the same word:
  - If MEM_WEN and MEM_REN fall in the same cycle, the read returns the old contents.
  - If MEM_REN falls in a later cycle than MEM_WEN, the read returns the new data.
- Address wrap: the maximum word address is 2^DEPTH-1. Upper address bits are not present, so there is no error response.
- Reset mid-transaction: the cycle after RST is sampled high, all outputs take their reset values. Pending AW/W data and reads are discarded without a response. A memory write that was already strobed stays written.

## Test plan
- Write-then-read, DEPTH=4:
  - Write: AW 0x08 and W 0xDEADBEEF in the same cycle → MEM_WEN one cycle later with MEM_WADDR=2, then BVALID with BRESP=0.
  - Read: AR 0x08 → RVALID 3 cycles after AR with RDATA=0xDEADBEEF.
- Split write:
  - W 0x12345678 is presented 5 cycles before AW 0x3C. WREADY must drop after the W handshake.
  - MEM_WEN follows the AW handshake by 1 cycle, with MEM_WADDR=15.
  - Readback of 0x3C = 0x12345678.
- Backpressure: hold BREADY=0 and RREADY=0 for 10 cycles → BVALID, RVALID and RDATA stay stable, AWREADY and ARREADY stay 0. Release both → each FSM returns to idle in the next cycle.
- Concurrent collision:
  - Word 1 holds 0xA.
  - Write 0xB to 0x04 while reading 0x04, timed so MEM_WEN and MEM_REN coincide → RDATA=0xA.
  - A second read → 0xB.
- Wrap: write 0x55 to byte address 0x3C, then read 0x3C. Also write 0x66 to 0x3D and read 0x3C → 0x66, because the byte offset is ignored.
- Reset mid-read: assert RST in the R_WAIT cycle → RVALID never rises and all outputs are 0 the next cycle. After release, a new read completes normally.
